// File: rtl/inv2x2_param_if.sv
// ---------------------------------------------------------------------------
// inv2x2_param_if
// Stream bundle between the serial operand source, the 2x2 inverse
// calculator and the result consumer.
//   in_valid  : source -> calc, high for 4 consecutive cycles per matrix
//   in_data   : source -> calc, elements a,b,c,d (row-major), IN_W signed
//   busy      : calc -> source, high from first accepted element to last beat
//   out_valid : calc -> consumer, result beat qualifier
//   out_data  : calc -> consumer, OUT_W signed fixed-point beat (0 when idle)
//   det_out   : calc -> consumer, signed determinant during result beats
//               (present only when INV2X2_DET_OUT_EN is defined)
// Modports: master = source/consumer side, slave = calculator side.
// ---------------------------------------------------------------------------
interface inv2x2_param_if #(
  parameter int IN_W   = 4,
  parameter int FRAC_W = 10
);
  localparam int OUT_W = IN_W + FRAC_W;
  localparam int DET_W = 2 * IN_W + 1;

  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             busy;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
`ifdef INV2X2_DET_OUT_EN
  logic [DET_W-1:0] det_out;

  modport master (output in_valid, output in_data,
                  input busy, input out_valid, input out_data, input det_out);
  modport slave  (input in_valid, input in_data,
                  output busy, output out_valid, output out_data, output det_out);
`else
  modport master (output in_valid, output in_data,
                  input busy, input out_valid, input out_data);
  modport slave  (input in_valid, input in_data,
                  output busy, output out_valid, output out_data);
`endif
endinterface

// File: rtl/inv2x2_param.sv
// ---------------------------------------------------------------------------
// inv2x2_param
// Serial 2x2 signed matrix inverse. Collects a,b,c,d, forms
// det = a*d - b*c, then produces e,f,g,h = (d,-b,-c,a)/det in fixed point
// with FRAC_W fraction bits using one shared restoring divider
// (OUT_W cycles per element, one quotient bit per cycle).
// A zero determinant yields a single zero beat instead.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : inv2x2_param_if.slave (in_valid/in_data in, busy/out_valid/out_data out)
// Optional build macro INV2X2_DET_OUT_EN adds bus.det_out, the signed
// determinant shown alongside every result beat.
// ---------------------------------------------------------------------------
module inv2x2_param #(
  parameter int IN_W   = 4,
  parameter int FRAC_W = 10
) (
  input logic           clk,
  input logic           rst,
  inv2x2_param_if.slave bus
);
  localparam int OUT_W = IN_W + FRAC_W;
  localparam int DET_W = 2 * IN_W + 1;
  localparam int REM_W = DET_W + 1;
  localparam int BIT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(OUT_W - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_DET  = 3'd2,
    S_DIV  = 3'd3,
    S_OUT  = 3'd4,
    S_ZERO = 3'd5
  } state_t;

  // Sign-extend an element to determinant width.
  function automatic logic [DET_W-1:0] sext_det(input logic [IN_W-1:0] x);
    sext_det = {{(DET_W - IN_W){x[IN_W-1]}}, x};
  endfunction

  // |x << FRAC_W| as an unsigned OUT_W value; -2^(IN_W-1) maps to 2^(OUT_W-1).
  function automatic logic [OUT_W-1:0] num_mag(input logic [IN_W-1:0] x);
    logic [OUT_W-1:0] s;
    s = {x, {FRAC_W{1'b0}}};
    if (x[IN_W-1]) begin
      num_mag = ~s + OUT_W'(1'b1);
    end else begin
      num_mag = s;
    end
  endfunction

  // Numerator for result slot idx: e<-d, f<-b, g<-c, h<-a.
  function automatic logic [IN_W-1:0] sel_elem(input logic [1:0] idx,
                                               input logic [IN_W-1:0] a,
                                               input logic [IN_W-1:0] b,
                                               input logic [IN_W-1:0] c,
                                               input logic [IN_W-1:0] d);
    case (idx)
      2'd0:    sel_elem = d;
      2'd1:    sel_elem = b;
      2'd2:    sel_elem = c;
      2'd3:    sel_elem = a;
      default: sel_elem = a;
    endcase
  endfunction

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_cnt;
  logic [IN_W-1:0]  r_a, r_b, r_c, r_d;
  logic [DET_W-1:0] r_det;
  logic [1:0]       r_idx;
  logic [BIT_W-1:0] r_bit;
  logic [OUT_W-1:0] r_num;      // dividend bits shift out, quotient bits shift in
  logic             r_num_neg;  // sign of the current numerator element
  logic [DET_W-1:0] r_rem;
  logic [OUT_W-1:0] r_res [4];
  logic             r_busy, w_busy_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [OUT_W-1:0] r_out, w_out_nxt;
`ifdef INV2X2_DET_OUT_EN
  logic [DET_W-1:0] r_det_out, w_det_out_nxt;
`endif

  logic signed [DET_W-1:0] w_ad, w_bc;
  logic [DET_W-1:0] w_det_calc;
  logic [DET_W-1:0] w_det_mag;
  logic [REM_W-1:0] w_rem_t, w_den;
  logic             w_ge;
  logic [DET_W-1:0] w_rem_nxt;
  logic [OUT_W-1:0] w_q_mag, w_q_fixed;
  logic             w_q_neg;
  logic [IN_W-1:0]  w_nxt_elem;

  assign w_ad       = $signed(sext_det(r_a)) * $signed(sext_det(r_d));
  assign w_bc       = $signed(sext_det(r_b)) * $signed(sext_det(r_c));
  assign w_det_calc = w_ad - w_bc;

  // Restoring step on magnitudes: remainder after this step always fits DET_W.
  assign w_det_mag  = r_det[DET_W-1] ? (~r_det + DET_W'(1'b1)) : r_det;
  assign w_rem_t    = {r_rem, r_num[OUT_W-1]};
  assign w_den      = {1'b0, w_det_mag};
  assign w_ge       = (w_rem_t >= w_den);
  assign w_rem_nxt  = w_ge ? DET_W'(w_rem_t - w_den) : w_rem_t[DET_W-1:0];
  assign w_q_mag    = {r_num[OUT_W-2:0], w_ge};

  // f and g carry an extra negation; the low OUT_W bits give the wrap.
  assign w_q_neg    = r_num_neg ^ r_det[DET_W-1] ^ ((r_idx == 2'd1) || (r_idx == 2'd2));
  assign w_q_fixed  = w_q_neg ? (~w_q_mag + OUT_W'(1'b1)) : w_q_mag;
  assign w_nxt_elem = sel_elem(r_idx + 2'd1, r_a, r_b, r_c, r_d);

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_busy_nxt      = r_busy;
    w_out_valid_nxt = 1'b0;
    w_out_nxt       = {OUT_W{1'b0}};
`ifdef INV2X2_DET_OUT_EN
    w_det_out_nxt   = {DET_W{1'b0}};
`endif
    case (r_state)
      S_IDLE: begin
        // busy still set means the last beat just left: force one idle cycle
        if (r_busy) begin
          w_busy_nxt = 1'b0;
        end else if (bus.in_valid) begin
          w_state_nxt = S_LOAD;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (!bus.in_valid) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else if (r_cnt == 2'd3) begin
          w_state_nxt = S_DET;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_DET: begin
        if (w_det_calc == {DET_W{1'b0}}) begin
          w_state_nxt = S_ZERO;
        end else begin
          w_state_nxt = S_DIV;
        end
      end
      S_DIV: begin
        if ((r_bit == LAST_BIT) && (r_idx == 2'd3)) begin
          w_state_nxt = S_OUT;
        end else begin
          w_state_nxt = S_DIV;
        end
      end
      S_OUT: begin
        w_out_valid_nxt = 1'b1;
        w_out_nxt       = r_res[r_idx];
`ifdef INV2X2_DET_OUT_EN
        w_det_out_nxt   = r_det;
`endif
        if (r_idx == 2'd3) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_OUT;
        end
      end
      S_ZERO: begin
        w_out_valid_nxt = 1'b1;
`ifdef INV2X2_DET_OUT_EN
        w_det_out_nxt   = r_det;
`endif
        w_state_nxt     = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= {OUT_W{1'b0}};
`ifdef INV2X2_DET_OUT_EN
      r_det_out   <= {DET_W{1'b0}};
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= w_busy_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out       <= w_out_nxt;
`ifdef INV2X2_DET_OUT_EN
      r_det_out   <= w_det_out_nxt;
`endif
    end
  end

  // Operand capture, determinant and shared divider datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 2'd0;
      r_a       <= {IN_W{1'b0}};
      r_b       <= {IN_W{1'b0}};
      r_c       <= {IN_W{1'b0}};
      r_d       <= {IN_W{1'b0}};
      r_det     <= {DET_W{1'b0}};
      r_idx     <= 2'd0;
      r_bit     <= {BIT_W{1'b0}};
      r_num     <= {OUT_W{1'b0}};
      r_num_neg <= 1'b0;
      r_rem     <= {DET_W{1'b0}};
      for (int i = 0; i < 4; i++) begin
        r_res[i] <= {OUT_W{1'b0}};
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && !r_busy) begin
            r_a   <= bus.in_data;
            r_cnt <= 2'd1;
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            case (r_cnt)
              2'd1:    r_b <= bus.in_data;
              2'd2:    r_c <= bus.in_data;
              2'd3:    r_d <= bus.in_data;
              default: r_a <= r_a;
            endcase
            r_cnt <= r_cnt + 2'd1;
          end else begin
            r_cnt <= 2'd0;
          end
        end
        S_DET: begin
          // Preload the first division (e uses d) so DIV starts immediately.
          r_det     <= w_det_calc;
          r_num     <= num_mag(r_d);
          r_num_neg <= r_d[IN_W-1];
          r_rem     <= {DET_W{1'b0}};
          r_bit     <= {BIT_W{1'b0}};
          r_idx     <= 2'd0;
        end
        S_DIV: begin
          if (r_bit == LAST_BIT) begin
            // Last quotient bit: store signed result and load next numerator.
            r_res[r_idx] <= w_q_fixed;
            r_num        <= num_mag(w_nxt_elem);
            r_num_neg    <= w_nxt_elem[IN_W-1];
            r_rem        <= {DET_W{1'b0}};
            r_bit        <= {BIT_W{1'b0}};
            r_idx        <= r_idx + 2'd1;
          end else begin
            r_num <= w_q_mag;
            r_rem <= w_rem_nxt;
            r_bit <= r_bit + BIT_W'(1'b1);
          end
        end
        S_OUT: begin
          r_idx <= r_idx + 2'd1;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out;
`ifdef INV2X2_DET_OUT_EN
  assign bus.det_out   = r_det_out;
`endif

endmodule

// File: doc/inv2x2_param.md
Name: inv2x2_param

Overview:
- Parametrised successor to the 2x2 signed inverse-matrix calculator.
- Accepts a 2x2 signed integer matrix serially, computes det = a*d - b*c, then produces the four inverse elements in fixed point (FRAC_W fraction bits) using one shared sequential restoring divider.
- Sits between the serial operand source and the result consumer; element width, fraction width and stream handshake are generalised.

Parameters:
- IN_W, 4, signed element width (>=2).
- FRAC_W, 10, fraction bits of each result.
- OUT_W (localparam), IN_W+FRAC_W, result width and divider iteration count.
- DET_W (localparam), 2*IN_W+1, determinant width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- IN_VALID  in  1  high for exactly 4 consecutive cycles per matrix.
- IN  in  IN_W  element a,b,c,d in row-major order, one per IN_VALID cycle.
- BUSY  out  1  high from the first accepted element until the last output beat.
- OUT_VALID  out  1  result beat qualifier.
- OUT  out  OUT_W  signed result beat.

Behaviour:
- Reset (rst high at an edge):
  - BUSY=0, OUT_VALID=0, OUT=0.
  - FSM returns to IDLE; element counter, det and quotient registers are cleared.
  - Reset mid-operation discards everything; no output follows.
- FSM states: IDLE, LOAD, DET, DIV, OUT, ZERO.
- IDLE: IN_VALID=1 samples a and goes to LOAD.
- LOAD: samples b, c, d on the next three edges.
  - If IN_VALID drops before d, abort: IDLE, BUSY=0, no output.
- DET: one cycle. det = a*d - b*c, computed in DET_W signed.
  - det==0 goes to ZERO; otherwise to DIV.
- DIV: four sequential divisions, OUT_W cycles each, one quotient bit per cycle, on magnitudes with sign fixed afterwards.
  - e = trunc((d<<FRAC_W)/det)
  - f = -trunc((b<<FRAC_W)/det)
  - g = -trunc((c<<FRAC_W)/det)
  - h = trunc((a<<FRAC_W)/det)
  - Truncation is toward zero. Numerator is sign-extended to OUT_W before the shift.
  - Results are stored as the low OUT_W bits (two's-complement wrap), e.g. +2^(OUT_W-1) wraps to -2^(OUT_W-1).
- OUT: OUT_VALID=1 for exactly 4 consecutive cycles carrying e, f, g, h, then IDLE.
- ZERO: OUT_VALID=1 for exactly 1 cycle with OUT=0, then IDLE.
- Latency: first OUT_VALID is asserted 2+4*OUT_W cycles after the edge sampling d (default 58); 2 for ZERO.
- OUT=0 whenever OUT_VALID=0.
- IN_VALID while in DET/DIV/OUT/ZERO is ignored; the source must wait for BUSY=0.
- IDLE with IN_VALID=1 in the same cycle that OUT/ZERO returns to IDLE: accepted next cycle only; one IDLE cycle minimum between matrices.

Optional Feature:
- Macro INV2X2_DET_OUT_EN.
- Defined: extra output port DET_OUT [DET_W-1:0], signed det, valid and stable while OUT_VALID=1 (both OUT and ZERO beats), 0 otherwise and on reset.
- Undefined: port and register absent; behaviour otherwise identical.

Test Plan:
- Defaults, a,b,c,d = 1,2,3,4 (det=-2) -> after 58 cycles, OUT = -2048, 1024, 1536, -512 on 4 consecutive OUT_VALID cycles; DET_OUT=-2 if enabled.
- a,b,c,d = 3,1,1,2 (det=5) -> OUT = 409, -204, -204, 614 (truncation toward zero).
- a,b,c,d = 0,1,1,-8 (det=-1) -> OUT = -8192 (wrapped 8192), 1024, 1024, 0.
- a,b,c,d = 2,4,1,2 (det=0) -> single OUT_VALID cycle, OUT=0, 2 cycles after d; no second beat.
- IN_VALID dropped after 2 elements -> BUSY falls, no OUT_VALID within 100 cycles; next full matrix 1,2,3,4 gives the correct result.
- rst pulsed during DIV -> OUT_VALID=0 and BUSY=0 next cycle, no stale output; then IN_W=6, FRAC_W=8 build with a,b,c,d = 31,0,0,-32 -> OUT = 8, 0, 0, -8.
